eeprom_rw_test: RTL and testbench

- Upstream sequencer for the IIC byte driver.
- Writes a pattern into NUM_BYTES consecutive EEPROM locations, waits out the write cycle after each byte, then reads every location back and compares it.
- Reports pass/fail, error count, first failing address and a driver-timeout flag, e.g. to board LEDs.

---
 rtl/iic_pkg.sv | 20 ++
 rtl/eeprom_rw_test_wait_timer.sv | 33 +++
 rtl/eeprom_rw_test.sv | 210 +++++++++++++++++++++
 tb/tb_eeprom_rw_test.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared constants for sequencers that sit upstream of the IIC byte driver.
package iic_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_TWR     = 3'd3;
    localparam logic [2:0] ST_RD_REQ  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic IIC_RD = 1'b1;
    localparam logic IIC_WR = 1'b0;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    // Wide enough for write-cycle and timeout counts up to 65536 cycles.
    localparam int TIMER_W = 16;

endpackage

// File: rtl/eeprom_rw_test_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module wait_timer
    import iic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/eeprom_rw_test.sv
// EEPROM write/read-back self test driving the IIC byte driver; results are
// held on level outputs until the next accepted Start.
module eeprom_rw_test #(
    parameter int          NUM_BYTES   = 16,
    parameter logic [15:0] START_ADDR  = 16'h0000,
    parameter logic [6:0]  SLAVE_ADDR  = iic_pkg::DEFAULT_SLAVE_ADDR,
    parameter logic        ADDR16      = 1'b1,
    parameter logic [7:0]  PATTERN     = 8'hA5,
    parameter int          TWR_CYC     = 5000,
    parameter int          TIMEOUT_CYC = 2000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    output logic        IIC_en,
    output logic [6:0]  IIC_slave_addr,
    output logic [15:0] IIC_dev_addr,
    output logic        IIC_bit_sel,
    output logic        IIC_rh_wl,
    output logic [7:0]  IIC_write_data,
    input  logic [7:0]  IIC_read_data,
    input  logic        IIC_done,
    output logic        Test_busy,
    output logic        Test_done,
    output logic        Test_pass,
    output logic        Test_timeout,
    output logic [7:0]  Err_cnt,
    output logic [15:0] First_err_addr,
    output logic [2:0]  Dbg_state
);

    import iic_pkg::*;

    localparam logic [7:0]         LAST_IDX = 8'(NUM_BYTES - 1);
    localparam logic [TIMER_W-1:0] TWR_LOAD = TIMER_W'(TWR_CYC - 1);
    localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        en_q, en_d;
    logic        rh_wl_q, rh_wl_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  err_q, err_d;
    logic [15:0] first_err_q, first_err_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expired;
    logic               req_d;

    wait_timer u_timer (
        .clk      (Clk),
        .rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Handshake: IIC_en is a one-cycle request; address, direction and write
    // data are registered on entry to the request state and held until the
    // driver's one-cycle IIC_done, which is only honoured in a WAIT state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        tmr_load    = 1'b0;
        tmr_val     = TO_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    err_d       = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    first_err_d = 16'hFFFF;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                tmr_load = 1'b1;
                state_d  = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (IIC_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TWR_LOAD;
                    state_d  = ST_TWR;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_TWR: begin
                if (tmr_expired) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                tmr_load = 1'b1;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (IIC_done) begin
                    if (IIC_read_data != (idx_q ^ PATTERN)) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (first_err_q == 16'hFFFF) begin
                            first_err_d = addr_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_RD_REQ;
                    end
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // err_q already includes the final compare, registered last cycle.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == 8'd0) && !timeout_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d   = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        en_d    = req_d;
        rh_wl_d = rh_wl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (req_d) begin
            rh_wl_d = (state_d == ST_RD_REQ) ? IIC_RD : IIC_WR;
            addr_d  = START_ADDR + {8'h00, idx_d};
            wdata_d = idx_d ^ PATTERN;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            en_q        <= 1'b0;
            rh_wl_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            first_err_q <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            rh_wl_q     <= rh_wl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
        end
    end

    assign IIC_en         = en_q;
    assign IIC_slave_addr = SLAVE_ADDR;
    assign IIC_dev_addr   = addr_q;
    assign IIC_bit_sel    = ADDR16;
    assign IIC_rh_wl      = rh_wl_q;
    assign IIC_write_data = wdata_q;
    assign Test_busy      = busy_q;
    assign Test_done      = done_q;
    assign Test_pass      = pass_q;
    assign Test_timeout   = timeout_q;
    assign Err_cnt        = err_q;
    assign First_err_addr = first_err_q;
    assign Dbg_state      = state_q;

endmodule

// File: tb/tb_eeprom_rw_test.sv
// Bench for eeprom_rw_test: two instances (plain and address-wrapping base)
// served by a loop-back EEPROM model with configurable latency and faults.
`timescale 1ns/1ps
module tb_eeprom_rw_test;
    import iic_pkg::*;

    localparam int         N   = 4;
    localparam int         TWR = 20;
    localparam int         TO  = 40;
    localparam logic [7:0] PAT = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start [2] = '{1'b0, 1'b0};
    logic        en    [2];
    logic [6:0]  slv   [2];
    logic [15:0] addr  [2];
    logic        bsel  [2];
    logic        rhwl  [2];
    logic [7:0]  wdata [2];
    logic [7:0]  rdata [2] = '{8'h00, 8'h00};
    logic        done  [2] = '{1'b0, 1'b0};
    logic        busy  [2];
    logic        tdone [2];
    logic        pass  [2];
    logic        tout  [2];
    logic [7:0]  errc  [2];
    logic [15:0] ferr  [2];
    logic [2:0]  dbg   [2];

    eeprom_rw_test #(.NUM_BYTES(N), .START_ADDR(16'h0010), .SLAVE_ADDR(7'h50), .ADDR16(1'b1),
                     .PATTERN(PAT), .TWR_CYC(TWR), .TIMEOUT_CYC(TO)) u_a (
        .Clk(clk), .Rst(rst), .Start(start[0]), .IIC_en(en[0]), .IIC_slave_addr(slv[0]),
        .IIC_dev_addr(addr[0]), .IIC_bit_sel(bsel[0]), .IIC_rh_wl(rhwl[0]),
        .IIC_write_data(wdata[0]), .IIC_read_data(rdata[0]), .IIC_done(done[0]),
        .Test_busy(busy[0]), .Test_done(tdone[0]), .Test_pass(pass[0]), .Test_timeout(tout[0]),
        .Err_cnt(errc[0]), .First_err_addr(ferr[0]), .Dbg_state(dbg[0]));

    eeprom_rw_test #(.NUM_BYTES(N), .START_ADDR(16'hFFFE), .SLAVE_ADDR(7'h50), .ADDR16(1'b1),
                     .PATTERN(PAT), .TWR_CYC(TWR), .TIMEOUT_CYC(TO)) u_b (
        .Clk(clk), .Rst(rst), .Start(start[1]), .IIC_en(en[1]), .IIC_slave_addr(slv[1]),
        .IIC_dev_addr(addr[1]), .IIC_bit_sel(bsel[1]), .IIC_rh_wl(rhwl[1]),
        .IIC_write_data(wdata[1]), .IIC_read_data(rdata[1]), .IIC_done(done[1]),
        .Test_busy(busy[1]), .Test_done(tdone[1]), .Test_pass(pass[1]), .Test_timeout(tout[1]),
        .Err_cnt(errc[1]), .First_err_addr(ferr[1]), .Dbg_state(dbg[1]));

    function automatic logic [15:0] base(input int g);
        logic [15:0] b;
        b = (g == 0) ? 16'h0010 : 16'hFFFE;
        return b;
    endfunction

    // ---------------- loop-back EEPROM model ----------------
    typedef struct {
        int          g;
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
    } txn_t;
    txn_t txn_q[$];

    int          lat     [2] = '{3, 3};
    logic [3:0]  cmask   [2] = '{4'h0, 4'h0};
    int          drop_at [2] = '{-1, -1};
    bit          spur    [2] = '{1'b0, 1'b0};
    bit          pend    [2] = '{1'b0, 1'b0};
    int          cnt     [2] = '{0, 0};
    bit          p_rw    [2] = '{1'b0, 1'b0};
    logic [15:0] p_addr  [2] = '{16'h0, 16'h0};
    logic [7:0]  p_data  [2] = '{8'h0, 8'h0};
    int          n_wr    [2] = '{0, 0};
    int          en_w    [2] = '{0, 0};
    int          wr_cyc  [2] = '{0, 0};
    bit          wr_seen [2] = '{1'b0, 1'b0};
    int          spur_c  [2] = '{0, 0};
    int          en_wmax = 0;
    int          gap_min = 1000000;
    int          gap_max = 0;
    logic [7:0]  mem [int];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int          k;
            int          gap;
            logic [15:0] ix;
            done[g] = 1'b0;
            if (rst) begin
                pend[g]    = 1'b0;
                en_w[g]    = 0;
                wr_seen[g] = 1'b0;
                spur_c[g]  = 0;
            end else begin
                if (en[g]) en_w[g]++; else en_w[g] = 0;
                if (en_w[g] > en_wmax) en_wmax = en_w[g];
                if (pend[g]) begin
                    if (cnt[g] <= 1) begin
                        pend[g] = 1'b0;
                        done[g] = 1'b1;
                        k = g * 65536 + int'(p_addr[g]);
                        if (p_rw[g]) begin
                            ix = p_addr[g] - base(g);
                            if (ix < 16'd4 && cmask[g][ix[1:0]]) rdata[g] = 8'h00;
                            else rdata[g] = mem.exists(k) ? mem[k] : 8'h00;
                        end else begin
                            mem[k]     = p_data[g];
                            wr_cyc[g]  = cyc;
                            wr_seen[g] = 1'b1;
                            if (spur[g]) spur_c[g] = 3;
                        end
                    end else begin
                        cnt[g]--;
                    end
                end else if (spur_c[g] > 0) begin
                    spur_c[g]--;
                    if (spur_c[g] == 0) done[g] = 1'b1;
                end
                if (en[g] && en_w[g] == 1) begin
                    if (wr_seen[g]) begin
                        gap = cyc - wr_cyc[g];
                        if (gap < gap_min) gap_min = gap;
                        if (gap > gap_max) gap_max = gap;
                        wr_seen[g] = 1'b0;
                    end
                    txn_q.push_back('{g, rhwl[g], addr[g], wdata[g]});
                    if (!rhwl[g]) n_wr[g]++;
                    if (rhwl[g] || n_wr[g] != drop_at[g]) begin
                        pend[g]   = 1'b1;
                        cnt[g]    = lat[g];
                        p_rw[g]   = rhwl[g];
                        p_addr[g] = addr[g];
                        p_data[g] = wdata[g];
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input int g);
        check("rst_en", en[g], 0);
        check("rst_addr", addr[g], 0);
        check("rst_rhwl", rhwl[g], 0);
        check("rst_wdata", wdata[g], 0);
        check("rst_busy", busy[g], 0);
        check("rst_done", tdone[g], 0);
        check("rst_pass", pass[g], 0);
        check("rst_tout", tout[g], 0);
        check("rst_err", errc[g], 0);
        check("rst_ferr", ferr[g], 16'hFFFF);
        check("rst_slave", slv[g], 7'h50);
        check("rst_bitsel", bsel[g], 1);
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic run(input int g, input int l, input logic [3:0] m, input int drop_k,
                       input bit sp, input bit poke, input bit e_pass, input bit e_tout,
                       input logic [7:0] e_err, input logic [15:0] e_ferr);
        int t0, waited, nw, bad;
        logic [24:0] e, o;
        lat[g]     = l;
        cmask[g]   = m;
        spur[g]    = sp;
        drop_at[g] = (drop_k == 0) ? -1 : n_wr[g] + drop_k;
        t0 = txn_q.size();
        pulse_start(g);
        check("first_en", en[g], 1);
        check("done_cleared", tdone[g], 0);
        check("busy_set", busy[g], 1);
        waited = 0;
        while (!tdone[g] && waited < 3000) begin
            start[g] = poke && (waited == 30 || waited == 100);
            @(negedge clk);
            waited++;
        end
        start[g] = 1'b0;
        check("finish_in_budget", waited < 3000, 1);
        check("busy_clear", busy[g], 0);
        check("pass", pass[g], e_pass);
        check("timeout", tout[g], e_tout);
        check("err_cnt", errc[g], e_err);
        check("first_err", ferr[g], e_ferr);

        exp_q.delete();
        nw = (drop_k == 0) ? N : drop_k;
        for (int i = 0; i < nw; i++) exp_q.push_back({1'b0, base(g) + 16'(i), 8'(i) ^ PAT});
        if (drop_k == 0)
            for (int i = 0; i < N; i++) exp_q.push_back({1'b1, base(g) + 16'(i), 8'h00});
        check("txn_count", txn_q.size() - t0, exp_q.size());
        bad = 0;
        for (int i = t0; i < txn_q.size(); i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            o = {txn_q[i].rw, txn_q[i].a, txn_q[i].rw ? 8'h00 : txn_q[i].d};
            if (txn_q[i].g != g || o !== e) bad++;
        end
        check("txn_seq", bad, 0);
    endtask

    typedef struct {
        int          g;
        int          l;
        logic [3:0]  m;
        int          drop;
        bit          sp;
        bit          e_pass;
        bit          e_tout;
        logic [7:0]  e_err;
        logic [15:0] e_ferr;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   waited, t0;
        vecs[0] = '{0, 3, 4'b0000, 0, 1'b0, 1'b1, 1'b0, 8'd0, 16'hFFFF};
        vecs[1] = '{0, 2, 4'b0100, 0, 1'b0, 1'b0, 1'b0, 8'd1, 16'h0012};
        vecs[2] = '{0, 4, 4'b0000, 2, 1'b0, 1'b0, 1'b1, 8'd0, 16'hFFFF};
        vecs[3] = '{1, 1, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 8'd0, 16'hFFFF};
        vecs[4] = '{1, 5, 4'b1100, 0, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0000};
        vecs[5] = '{1, 8, 4'b0011, 0, 1'b1, 1'b0, 1'b0, 8'd2, 16'hFFFE};
        vecs[6] = '{0, 1, 4'b1001, 0, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0010};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run(vecs[i].g, vecs[i].l, vecs[i].m, vecs[i].drop, vecs[i].sp, 1'b0,
                vecs[i].e_pass, vecs[i].e_tout, vecs[i].e_err, vecs[i].e_ferr);

        // Start pulsed twice while busy must not restart or extend the run.
        run(1, 3, 4'b0000, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'hFFFF);

        // Start coinciding with the finish cycle is dropped.
        lat[0] = 2; cmask[0] = 4'b0000; spur[0] = 1'b0; drop_at[0] = -1;
        pulse_start(0);
        waited = 0;
        while (dbg[0] != ST_FINISH && waited < 3000) begin @(negedge clk); waited++; end
        check("reach_finish", waited < 3000, 1);
        start[0] = 1'b1;
        t0 = txn_q.size();
        @(negedge clk);
        start[0] = 1'b0;
        check("fin_start_done", tdone[0], 1);
        check("fin_start_pass", pass[0], 1);
        repeat (3) @(negedge clk);
        check("fin_start_busy", busy[0], 0);
        check("fin_start_no_txn", txn_q.size() - t0, 0);

        // Reset while waiting on a read clears everything at once.
        lat[0] = 6;
        pulse_start(0);
        waited = 0;
        while (dbg[0] != ST_RD_WAIT && waited < 3000) begin @(negedge clk); waited++; end
        check("reach_rd_wait", waited < 3000, 1);
        rst = 1'b1;
        #1;
        check_reset(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(0, 3, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'hFFFF);

        // Randomised runs against a reference built from the mismatch rules.
        for (int r = 0; r < 6; r++) begin
            int          g, l;
            logic [3:0]  m;
            bit          sp;
            logic [7:0]  e_err;
            logic [15:0] e_ferr;
            g  = $urandom_range(0, 1);
            l  = $urandom_range(1, 8);
            m  = 4'($urandom_range(0, 15));
            sp = 1'($urandom_range(0, 1));
            e_err  = 8'd0;
            e_ferr = 16'hFFFF;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    e_err++;
                    if (e_ferr == 16'hFFFF) e_ferr = base(g) + 16'(i);
                end
            end
            run(g, l, m, 0, sp, 1'b0, e_err == 0, 1'b0, e_err, e_ferr);
        end

        check("en_width_max", en_wmax, 1);
        check("twr_gap_min", gap_min, TWR + 1);
        check("twr_gap_max", gap_max, TWR + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
